// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline types and constants for the MIPS core.
package mips_pkg;
    typedef enum logic {IDLE, MD_WAIT} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
    function automatic logic is_md_funct(input logic [5:0] funct);
        return funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the load in EX and the sources of the instruction in ID.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       ex_memtoreg,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu
);
    assign lu = ex_memtoreg && ex_rt != REG_ZERO && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline,
// covering load-use bubbles, branch flushes and the mult/div wait.
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_md,
    input  logic             branch_taken,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_rt,
    input  logic             md_done,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             ifid_clear,
    output logic             idex_le,
    output logic             idex_clear,
    output logic             md_go,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WW = $clog2(MD_TIMEOUT) > 0 ? $clog2(MD_TIMEOUT) : 1;
    state_t        state;
    logic [WW-1:0] wcnt;
    logic          lu, idle, waiting, lu_stall, issue, tmo;
    hazard_detect u_hazard_detect (
        .ex_memtoreg(ex_memtoreg),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .lu         (lu)
    );
    // Reset forces the combinational view to an unstalled IDLE.
    always_comb begin
        idle       = !reset && state == IDLE;
        waiting    = !reset && state == MD_WAIT;
        lu_stall   = idle && lu;
        issue      = idle && !lu && id_md;
        tmo        = waiting && !md_done && wcnt == WW'(MD_TIMEOUT - 1);
        pc_le      = !(waiting || lu_stall);
        ifid_le    = pc_le;
        idex_le    = !waiting;
        idex_clear = lu_stall;
        ifid_clear = idle && !lu && !id_md && branch_taken;
        md_busy    = waiting;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            md_go      <= 1'b0;
            md_timeout <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            md_go <= issue;
            if (!pc_le && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (issue) begin
                state <= MD_WAIT;
                wcnt  <= '0;
            end else if (waiting) begin
                wcnt <= wcnt + 1'b1;
                if (md_done || tmo) state <= IDLE;
                if (tmo) md_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of the hazard controller
// against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int SAT        = (1 << CNT_W) - 1;
    logic clk = 1'b0, reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic id_uses_rt = 1'b0, id_md = 1'b0, branch_taken = 1'b0, ex_memtoreg = 1'b0, md_done = 1'b0;
    logic pc_le, ifid_le, ifid_clear, idex_le, idex_clear, md_go, md_busy, md_timeout;
    logic [CNT_W-1:0] stall_cnt;
    int tests = 0, fails = 0;
    bit m_wait = 0, m_go = 0, m_to = 0;
    int m_waited = 0, m_stalls = 0;
    bit h, e_pc, e_ifid_le, e_ifid_clr, e_idex_le, e_idex_clr, e_busy;
    pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_md(id_md), .branch_taken(branch_taken), .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt),
        .md_done(md_done), .pc_le(pc_le), .ifid_le(ifid_le), .ifid_clear(ifid_clear),
        .idex_le(idex_le), .idex_clear(idex_clear), .md_go(md_go), .md_busy(md_busy),
        .md_timeout(md_timeout), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask
    // Model: expected outputs this cycle, then the state implied by this cycle's inputs.
    always @(negedge clk) begin
        h = ex_memtoreg && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        {e_pc, e_ifid_le, e_idex_le, e_ifid_clr, e_idex_clr, e_busy} = 6'b111000;
        if (!reset) begin
            if (m_wait) {e_pc, e_ifid_le, e_idex_le, e_busy} = 4'b0001;
            else if (h) {e_pc, e_ifid_le, e_idex_clr} = 3'b001;
            else if (!id_md && branch_taken) e_ifid_clr = 1;
        end
        chk("pc_le", pc_le, e_pc);
        chk("ifid_le", ifid_le, e_ifid_le);
        chk("ifid_clear", ifid_clear, e_ifid_clr);
        chk("idex_le", idex_le, e_idex_le);
        chk("idex_clear", idex_clear, e_idex_clr);
        chk("md_busy", md_busy, e_busy);
        chk("md_go", md_go, m_go);
        chk("md_timeout", md_timeout, m_to);
        chk("stall_cnt", stall_cnt, m_stalls);
        if (reset) begin
            {m_wait, m_go, m_to} = 3'b000;
            m_stalls = 0;
        end else begin
            if (!e_pc) m_stalls = m_stalls + 1 > SAT ? SAT : m_stalls + 1;
            m_go = !m_wait && !h && id_md;
            if (m_wait) begin
                m_waited++;
                if (md_done) m_wait = 0;
                else if (m_waited == MD_TIMEOUT) {m_wait, m_to} = 2'b01;
            end else if (m_go) begin
                m_wait   = 1;
                m_waited = 0;
            end
        end
    end
    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic quiet();
        {id_rs, id_rt, ex_rt} = '0;
        {id_uses_rt, id_md, branch_taken, ex_memtoreg, md_done} = '0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask
    initial begin
        quiet();
        cyc(2);
        reset = 1'b0;
        // load-use: one bubble, then free-running
        ex_memtoreg = 1; ex_rt = 8; id_rs = 8;
        #1 chk("lu pc_le", pc_le, 0);
        chk("lu idex_clear", idex_clear, 1);
        cyc(1);
        quiet();
        #1 chk("lu after pc_le", pc_le, 1);
        chk("lu stall_cnt", stall_cnt, 1);
        // $zero and unused rt never stall
        ex_memtoreg = 1; ex_rt = 0; id_rs = 0;
        #1 chk("zero reg pc_le", pc_le, 1);
        ex_rt = 9; id_rs = 3; id_rt = 9; id_uses_rt = 0;
        #1 chk("unused rt pc_le", pc_le, 1);
        cyc(1);
        quiet();
        branch_taken = 1;
        #1 chk("branch ifid_clear", ifid_clear, 1);
        chk("branch pc_le", pc_le, 1);
        ex_memtoreg = 1; ex_rt = 4; id_rt = 4; id_uses_rt = 1;
        #1 chk("branch+lu ifid_clear", ifid_clear, 0);
        chk("branch+lu pc_le", pc_le, 0);
        cyc(1);
        quiet();
        // mult/div finishing in the 6th wait cycle
        do_reset();
        id_md = 1;
        cyc(1);
        id_md = 0;
        chk("md_go pulse", md_go, 1);
        chk("md_busy", md_busy, 1);
        cyc(5);
        chk("md_go one cycle", md_go, 0);
        md_done = 1;
        cyc(1);
        md_done = 0;
        #1 chk("md done busy", md_busy, 0);
        chk("md done pc_le", pc_le, 1);
        chk("md stall_cnt", stall_cnt, 6);
        // timeout after MD_TIMEOUT wait cycles, sticky until reset
        do_reset();
        id_md = 1;
        cyc(1);
        id_md = 0;
        cyc(MD_TIMEOUT);
        chk("timeout flag", md_timeout, 1);
        chk("timeout busy", md_busy, 0);
        chk("timeout stall_cnt", stall_cnt, 8);
        cyc(3);
        chk("timeout sticky", md_timeout, 1);
        do_reset();
        chk("timeout cleared", md_timeout, 0);
        // reset in the 3rd wait cycle
        id_md = 1;
        cyc(1);
        id_md = 0;
        cyc(2);
        reset = 1;
        #1 chk("reset mid pc_le", pc_le, 1);
        chk("reset mid busy", md_busy, 0);
        cyc(1);
        reset = 0;
        chk("reset mid md_go", md_go, 0);
        chk("reset mid stall_cnt", stall_cnt, 0);
        cyc(1);
        chk("reset mid no reissue", md_go, 0);
        chk("reset mid idle", md_busy, 0);
        // saturation
        ex_memtoreg = 1; ex_rt = 5; id_rs = 5;
        cyc(20);
        chk("saturation", stall_cnt, SAT);
        quiet();
        do_reset();
        repeat (3000) begin
            reset        = $urandom_range(0, 99) == 0;
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_memtoreg  = $urandom_range(0, 2) == 0;
            id_md        = $urandom_range(0, 7) == 0;
            branch_taken = $urandom_range(0, 3) == 0;
            md_done      = $urandom_range(0, 9) == 0;
            cyc(1);
        end
        quiet();
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
